ref_row_feeder: RTL and testbench
=================================

REF_ROW_FEEDER -- requirements
Module: ref_row_feeder

Interface
REQ-001 SHALL have parameter PIX_W, default 8, bits per luma sample.
REQ-002 SHALL have parameter ROW_PIX, default 15, samples per reference row (8 interpolated + 7 filter taps).
REQ-003 SHALL have parameter NUM_ROWS, default 15, rows per reference block.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous reset, active-low (rst==0 resets).
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a new block.
REQ-007 SHALL have port in_data  in  8*PIX_W  8 samples per beat, sample k at bits [k*PIX_W +: PIX_W].
REQ-008 SHALL have port in_valid / in_ready  in / out  1 each  input beat handshake.
REQ-009 SHALL have port row_data  out  ROW_PIX*PIX_W  assembled row; sample k at bits [k*PIX_W +: PIX_W].
REQ-010 SHALL have port row_valid / row_ready  out / in  1 each  row handshake toward the interpolator's input shift register.
REQ-011 SHALL have port row_idx  out  4  index of the presented row, 0..NUM_ROWS-1.
REQ-012 SHALL have port busy  out  1, and port done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-013 SHALL transfer a beat only on in_valid&&in_ready, and a row only on row_valid&&row_ready.
REQ-014 SHALL use BEATS=ceil(ROW_PIX/8) beats per row; unused high samples of the final beat are discarded.
REQ-015 SHALL implement states IDLE, FILL, DRAIN: IDLE->FILL on start; FILL->DRAIN when the last beat of row NUM_ROWS-1 is accepted; DRAIN->IDLE when the last row is accepted on the output.
REQ-016 SHALL buffer assembled rows in a 2-entry row FIFO; in_ready = (state==FILL) && FIFO not full-after-assembly (the assembly register may fill while 2 rows wait).
REQ-017 SHALL present a completed row on row_valid in the cycle after its final beat is accepted (latency 1 cycle, FIFO empty case).
REQ-018 SHALL sustain one row every BEATS cycles when in_valid and row_ready are held high.
REQ-019 SHALL hold row_data and row_idx stable while row_valid && !row_ready.
REQ-020 SHALL ignore start outside IDLE; start in the same cycle as done SHALL be accepted (next block begins).
REQ-021 SHALL count rows modulo NUM_ROWS with a beat counter wrapping at BEATS-1 and a row counter wrapping at NUM_ROWS-1.
REQ-022 SHALL drive busy=1 in FILL and DRAIN; done SHALL pulse in the cycle the state returns to IDLE.

Reset
REQ-023 On rst==0 asynchronously: state=IDLE, counters=0, FIFO empty, row_valid=0, in_ready=0, row_data=0, row_idx=0, busy=0, done=0.
REQ-024 Reset mid-block SHALL discard all partial and buffered rows; no done pulse is produced.

Configuration
REQ-025 Macro FEEDER_PROTO_CHECK_EN: when defined, adds output err (1 bit, sticky until reset/start-in-IDLE) set when in_valid is high in IDLE or start pulses outside IDLE; when undefined, err is absent and such events are silently ignored.

Structure
REQ-026 Shared package SHALL hold the state enum (IDLE/FILL/DRAIN), PIX_W default and the BEATS computation function.
REQ-027 Row FIFO SHALL be a sub-module named row_fifo2 (2-entry, valid/ready both sides, width ROW_PIX*PIX_W).

Verification
REQ-028 Start, 30 beats in_valid=1, row_ready=1, beat n sample k = n*8+k -> 15 rows; row 0 samples 0..14 = 0..14; done 1 cycle after row 14 accepted.
REQ-029 row_ready=0 for 20 cycles mid-block -> two rows buffered, in_ready drops after third row assembled, row_data stable, no loss.
REQ-030 in_valid toggling every other cycle -> row rate halves, row_idx still 0..14 in order.
REQ-031 rst low after 7 rows -> all outputs zero immediately; new start yields row_idx 0 with fresh data.
REQ-032 start pulsed during FILL -> ignored, block completes normally; with FEEDER_PROTO_CHECK_EN err=1.
REQ-033 start asserted in done cycle -> busy stays high, next block rows 0..14 delivered.

Source files
------------

// File: rtl/ref_row_feeder_pkg.sv
// Shared types and sizing helpers for the reference-row feeder.
package ref_row_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } feeder_state_e;

  localparam int PIX_W_DEF = 8;
  localparam int LANES     = 8;

  function automatic int calc_beats(input int row_pix);
    return (row_pix + LANES - 1) / LANES;
  endfunction

endpackage

// File: rtl/ref_row_feeder_row_fifo2.sv
// Two-entry row FIFO with valid/ready on both sides; no same-cycle bypass.
module row_fifo2 #(
  parameter int W = 120
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] mem0_q, mem1_q;
  logic         wr_ptr_q, rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_q) mem1_q <= in_data_i;
        else          mem0_q <= in_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/ref_row_feeder.sv
// Assembles 8-sample input beats into reference rows and streams them out.
// Optional FEEDER_PROTO_CHECK_EN adds a sticky protocol error output err.
module ref_row_feeder
  import ref_row_feeder_pkg::*;
#(
  parameter int PIX_W    = PIX_W_DEF,
  parameter int ROW_PIX  = 15,
  parameter int NUM_ROWS = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LANES*PIX_W-1:0]   in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ROW_PIX*PIX_W-1:0] row_data,
  output logic                     row_valid,
  input  logic                     row_ready,
  output logic [3:0]               row_idx,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_PROTO_CHECK_EN
  ,
  output logic                     err
`endif
);

  localparam int BEATS = calc_beats(ROW_PIX);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int ROW_W = ROW_PIX * PIX_W;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [3:0]    ROW_LAST  = 4'(NUM_ROWS - 1);

  feeder_state_e state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [3:0]    in_row_q, in_row_d;
  logic [3:0]    out_row_q, out_row_d;
  logic [ROW_W-1:0] asm_q, asm_d;
  logic          done_q, done_d;
  logic          fifo_ready, beat_fire, beat_last, push, row_fire;

  assign beat_last = (beat_q == BEAT_LAST);
  // The final beat needs a free FIFO slot; earlier beats only touch the assembly register.
  assign in_ready  = (state_q == ST_FILL) && !(beat_last && !fifo_ready);
  assign beat_fire = in_valid && in_ready;
  assign push      = beat_fire && beat_last;
  assign row_fire  = row_valid && row_ready;

  always_comb begin
    asm_d = asm_q;
    if (beat_fire) begin
      for (int k = 0; k < LANES; k++) begin
        if (int'(beat_q) * LANES + k < ROW_PIX)
          asm_d[(int'(beat_q) * LANES + k) * PIX_W +: PIX_W] = in_data[k*PIX_W +: PIX_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    in_row_d  = in_row_q;
    out_row_d = out_row_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_FILL;
          beat_d    = '0;
          in_row_d  = '0;
          out_row_d = '0;
        end
      end
      ST_FILL:  if (push && in_row_q == ROW_LAST) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (row_fire && out_row_q == ROW_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (beat_fire) beat_d   = beat_last ? '0 : beat_q + 1'b1;
    if (push)      in_row_d = (in_row_q == ROW_LAST) ? 4'd0 : in_row_q + 4'd1;
    if (row_fire)  out_row_d = (out_row_q == ROW_LAST) ? 4'd0 : out_row_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      in_row_q  <= '0;
      out_row_q <= '0;
      asm_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      in_row_q  <= in_row_d;
      out_row_q <= out_row_d;
      asm_q     <= asm_d;
      done_q    <= done_d;
    end
  end

  row_fifo2 #(.W(ROW_W)) u_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .in_data_i   (asm_d),
    .in_valid_i  (push),
    .in_ready_o  (fifo_ready),
    .out_data_o  (row_data),
    .out_valid_o (row_valid),
    .out_ready_i (row_ready)
  );

  assign row_idx = out_row_q;
  assign done    = done_q;
  // A restart in the done cycle keeps busy asserted across the block boundary.
  assign busy    = (state_q != ST_IDLE) || (done_q && start);

`ifdef FEEDER_PROTO_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start && state_q == ST_IDLE) err_d = 1'b0;
    if ((in_valid && state_q == ST_IDLE) || (start && state_q != ST_IDLE)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_ref_row_feeder.sv
// Randomized self-checking bench for ref_row_feeder against a queue-based row model.
module tb_ref_row_feeder;

  localparam int PIX_W    = 8;
  localparam int ROW_PIX  = 15;
  localparam int NUM_ROWS = 15;
  localparam int BEATS    = (ROW_PIX + 7) / 8;
  localparam int ROW_W    = ROW_PIX * PIX_W;
  localparam int IN_W     = 8 * PIX_W;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_ready, row_valid, row_ready, busy, done;
  logic [IN_W-1:0]  in_data;
  logic [ROW_W-1:0] row_data;
  logic [3:0]       row_idx;
`ifdef FEEDER_PROTO_CHECK_EN
  logic             err;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int vmode, rmode, dmode;

  always #5 clk = ~clk;

  ref_row_feeder #(.PIX_W(PIX_W), .ROW_PIX(ROW_PIX), .NUM_ROWS(NUM_ROWS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_data  (row_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done)
`ifdef FEEDER_PROTO_CHECK_EN
    ,
    .err       (err)
`endif
  );

  task automatic chk_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole-block view, beats collected per row, rows queued until accepted.
  bit               active;
  bit               done_exp;
  int               rows_asm, rows_acc;
  logic [IN_W-1:0]  beat_buf[$];
  logic [ROW_W-1:0] exp_q[$];

  function automatic logic [ROW_W-1:0] build_row();
    logic [ROW_W-1:0] r;
    logic [IN_W-1:0]  b;
    r = '0;
    for (int j = 0; j < ROW_PIX; j++) begin
      b = beat_buf[j / 8];
      r[j*PIX_W +: PIX_W] = b[(j % 8)*PIX_W +: PIX_W];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bit was_active;
    bit done_nx;
    bit exp_rdy;
    int pend;
    if (!rst) begin
      active   = 1'b0;
      done_exp = 1'b0;
      rows_asm = 0;
      rows_acc = 0;
      beat_buf.delete();
      exp_q.delete();
    end else begin
      pend    = exp_q.size();
      exp_rdy = active && rows_asm < NUM_ROWS && !(beat_buf.size() == BEATS - 1 && pend >= 2);
      chk_val("row_valid", 256'(row_valid), 256'(pend > 0));
      chk_val("in_ready",  256'(in_ready),  256'(exp_rdy));
      chk_val("busy",      256'(busy),      256'(active || (done_exp && start)));
      chk_val("done",      256'(done),      256'(done_exp));
      if (row_valid && pend > 0) begin
        chk_val("row_data", 256'(row_data), 256'(exp_q[0]));
        chk_val("row_idx",  256'(row_idx),  256'(rows_acc));
      end
      was_active = active;
      done_nx    = 1'b0;
      if (active && in_valid && in_ready) begin
        beat_buf.push_back(in_data);
        if (beat_buf.size() == BEATS) begin
          exp_q.push_back(build_row());
          beat_buf.delete();
          rows_asm++;
        end
      end
      if (row_valid && row_ready && pend > 0) begin
        void'(exp_q.pop_front());
        rows_acc++;
        if (rows_acc == NUM_ROWS) begin
          active  = 1'b0;
          done_nx = 1'b1;
        end
      end
      if (start && !was_active) begin
        active   = 1'b1;
        rows_asm = 0;
        rows_acc = 0;
        beat_buf.delete();
      end
      done_exp = done_nx;
    end
  end

  task automatic set_inputs(input int c, input int stall_from, input int stall_len);
    int n;
    start    = 1'b0;
    in_valid = active && (vmode == 0 || (vmode == 1 && c % 2 == 0) ||
                          (vmode == 2 && $urandom_range(0, 1) == 1));
    if (c >= stall_from && c < stall_from + stall_len) row_ready = 1'b0;
    else row_ready = (rmode == 0) || ($urandom_range(0, 3) != 0);
    n = rows_asm * BEATS + beat_buf.size();
    for (int k = 0; k < 8; k++)
      in_data[k*PIX_W +: PIX_W] = (dmode == 0) ? PIX_W'(n * 8 + k) : PIX_W'($urandom);
  endtask

  task automatic run_block(input int stall_from, input int stall_len, input int start_at,
                           input int stop_rows, input int budget);
    bit finished;
    finished = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (!active || rows_acc >= stop_rows) begin
        finished = 1'b1;
        break;
      end
      set_inputs(c, stall_from, stall_len);
      if (c == start_at) start = 1'b1;
    end
    if (!finished) chk_val("block_timeout", 256'(active), 256'(0));
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_now();
    start    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic begin_block();
    @(posedge clk); #1;
    start_now();
  endtask

  task automatic check_reset(input string tag);
    chk_val({tag, "_row_valid"}, 256'(row_valid), 256'(0));
    chk_val({tag, "_in_ready"},  256'(in_ready),  256'(0));
    chk_val({tag, "_row_data"},  256'(row_data),  256'(0));
    chk_val({tag, "_row_idx"},   256'(row_idx),   256'(0));
    chk_val({tag, "_busy"},      256'(busy),      256'(0));
    chk_val({tag, "_done"},      256'(done),      256'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; row_ready = 1'b0; in_data = '0;
    vmode = 0; rmode = 0; dmode = 0;
    #2 rst = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Streaming block with counting pattern, then restart in the done cycle.
    begin_block();
    run_block(-100, 0, -1, 99, 200);
    start_now();
    run_block(-100, 0, -1, 99, 200);

    // Output stall mid-block with random data.
    dmode = 1;
    begin_block();
    run_block(8, 20, -1, 99, 300);

    // Input valid every other cycle.
    vmode = 1;
    begin_block();
    run_block(-100, 0, -1, 99, 300);

    // Spurious start during FILL.
    vmode = 0;
    begin_block();
    run_block(-100, 0, 10, 99, 300);
`ifdef FEEDER_PROTO_CHECK_EN
    chk_val("err_set", 256'(err), 256'(1));
`endif

    // Reset after seven rows, then a fresh block.
    begin_block();
    run_block(-100, 0, -1, 7, 300);
    #2 rst = 1'b0;
    #1 check_reset("mid_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    begin_block();
    run_block(-100, 0, -1, 99, 300);
`ifdef FEEDER_PROTO_CHECK_EN
    chk_val("err_clr", 256'(err), 256'(0));
`endif

    // Random valid/ready traffic.
    vmode = 2;
    rmode = 1;
    for (int b = 0; b < 6; b++) begin
      begin_block();
      run_block(-100, 0, -1, 99, 800);
    end

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
